// File: rtl/bch_ctrl_pkg.sv
// Shared types and constants for the BCH run sequencer: FSM states,
// stage indices and fault codes.
package bch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] STG_ENC    = 2'd0;
    localparam logic [1:0] STG_NOISE  = 2'd1;
    localparam logic [1:0] STG_ERRGEN = 2'd2;
    localparam logic [1:0] STG_DEC    = 2'd3;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_TIMEOUT = 2'd1;
    localparam logic [1:0] FLT_CFG     = 2'd2;
    localparam logic [1:0] FLT_ABORT   = 2'd3;

    function automatic logic [3:0] stage_onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/bch_stage_select.sv
// Finds the lowest enabled stage index at or above (incl=1) or strictly
// above (incl=0) the current index; none=1 when no such stage exists.
module bch_stage_select
    import bch_ctrl_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] cur,
    input  logic       incl,
    output logic [1:0] nxt,
    output logic       none
);

    always_comb begin
        nxt  = cur;
        none = 1'b1;
        // Descending scan so the lowest qualifying index is the last write.
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && ((2'(i) > cur) || (incl && (2'(i) == cur)))) begin
                nxt  = 2'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bch_flow_ctrl.sv
// Run sequencer for the BCH test datapath: launches ENC, NOISE, ERRGEN and DEC
// in order, skipping disabled stages, with a per-stage watchdog and run stats.
module bch_flow_ctrl
    import bch_ctrl_pkg::*;
#(
    parameter int CODE_LEN       = 14,
    parameter int MAX_T          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cfg_encode_en_i,
    input  logic             cfg_noise_en_i,
    input  logic             cfg_errgen_en_i,
    input  logic [7:0]       cfg_num_errors_i,
    input  logic [2:0]       cfg_t_i,
    output logic [3:0]       stg_start_o,
    input  logic [3:0]       stg_done_i,
    output logic [7:0]       err_count_o,
    output logic [3:0]       syn_count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fault_o,
    output logic [1:0]       fault_code_o,
    output logic [1:0]       fault_stage_o,
    output logic [1:0]       cur_stage_o,
    output logic [15:0]      run_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [2:0]       dbg_state_o
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_n;
    logic [1:0]       stage, stage_n;
    logic [3:0]       mask_q;
    logic [TMR_W-1:0] timer;
    logic             cnt_run;

    logic       start_acc, cfg_bad, done_entry, flt_set;
    logic [1:0] flt_code;
    logic [3:0] cfg_mask;
    logic [1:0] first_idx, next_idx;
    logic       first_none, next_none;

    assign cfg_mask = {cfg_encode_en_i, cfg_errgen_en_i, cfg_noise_en_i, cfg_encode_en_i};
    assign cfg_bad  = (cfg_errgen_en_i && (cfg_num_errors_i > 8'(CODE_LEN))) ||
                      (cfg_encode_en_i && ((cfg_t_i == 3'd0) || (cfg_t_i > 3'(MAX_T))));
    assign start_acc = start_i &&
                       ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAULT));

    bch_stage_select u_first (
        .mask (cfg_mask),
        .cur  (STG_ENC),
        .incl (1'b1),
        .nxt  (first_idx),
        .none (first_none)
    );

    bch_stage_select u_next (
        .mask (mask_q),
        .cur  (stage),
        .incl (1'b0),
        .nxt  (next_idx),
        .none (next_none)
    );

    // Stage handshake: a one-cycle stg_start_o pulse launches an engine; its
    // stg_done_i pulse is honoured only in WAIT and only for the current stage.
    always_comb begin
        state_n  = state;
        stage_n  = stage;
        flt_set  = 1'b0;
        flt_code = FLT_NONE;
        case (state)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start_acc) begin
                    if (cfg_bad) begin
                        state_n  = ST_FAULT;
                        stage_n  = STG_ENC;
                        flt_set  = 1'b1;
                        flt_code = FLT_CFG;
                    end else if (first_none) begin
                        state_n = ST_DONE;
                        stage_n = STG_ENC;
                    end else begin
                        state_n = ST_ISSUE;
                        stage_n = first_idx;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    state_n  = ST_FAULT;
                    flt_set  = 1'b1;
                    flt_code = FLT_ABORT;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    state_n  = ST_FAULT;
                    flt_set  = 1'b1;
                    flt_code = FLT_ABORT;
                end else if (stg_done_i[stage]) begin
                    if (next_none) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ISSUE;
                        stage_n = next_idx;
                    end
                end else if (timer == TMR_LAST) begin
                    state_n  = ST_FAULT;
                    flt_set  = 1'b1;
                    flt_code = FLT_TIMEOUT;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign done_entry  = (state_n == ST_DONE) && ((state != ST_DONE) || start_acc);
    assign cur_stage_o = stage;
    assign dbg_state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            stage         <= STG_ENC;
            mask_q        <= '0;
            timer         <= '0;
            cnt_run       <= 1'b0;
            stg_start_o   <= '0;
            err_count_o   <= '0;
            syn_count_o   <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            fault_o       <= 1'b0;
            fault_code_o  <= FLT_NONE;
            fault_stage_o <= '0;
            run_cnt_o     <= '0;
            cycle_cnt_o   <= '0;
        end else begin
            state       <= state_n;
            stage       <= stage_n;
            stg_start_o <= (state_n == ST_ISSUE) ? stage_onehot(stage_n) : 4'b0000;
            busy_o      <= (state_n == ST_ISSUE) || (state_n == ST_WAIT);
            timer       <= (state == ST_WAIT) ? timer + 1'b1 : '0;

            // The run counter covers acceptance through the first DONE/FAULT cycle.
            if (start_acc) begin
                mask_q        <= cfg_mask;
                err_count_o   <= cfg_num_errors_i;
                syn_count_o   <= {cfg_t_i, 1'b0};
                done_o        <= 1'b0;
                fault_o       <= 1'b0;
                fault_code_o  <= FLT_NONE;
                fault_stage_o <= '0;
                cycle_cnt_o   <= CNT_W'(1);
                cnt_run       <= 1'b1;
            end else if (cnt_run) begin
                if (cycle_cnt_o != '1) begin
                    cycle_cnt_o <= cycle_cnt_o + 1'b1;
                end
                if ((state == ST_DONE) || (state == ST_FAULT)) begin
                    cnt_run <= 1'b0;
                end
            end

            if (done_entry) begin
                done_o    <= 1'b1;
                run_cnt_o <= run_cnt_o + 1'b1;
            end
            if (flt_set) begin
                fault_o       <= 1'b1;
                fault_code_o  <= flt_code;
                fault_stage_o <= stage_n;
            end
        end
    end

endmodule

// File: tb/tb_bch_flow_ctrl.sv
// Self-checking bench for bch_flow_ctrl: table-driven runs plus hand-written
// timeout, abort, busy-start and reset sequences, with a stage-start scoreboard.
module tb_bch_flow_ctrl;

    localparam int ENG_DELAY = 5;

    logic        clk, rst;
    logic        start_i, abort_i;
    logic        cfg_encode_en_i, cfg_noise_en_i, cfg_errgen_en_i;
    logic [7:0]  cfg_num_errors_i;
    logic [2:0]  cfg_t_i;
    logic [3:0]  stg_start_o, stg_done_i;
    logic [7:0]  err_count_o;
    logic [3:0]  syn_count_o;
    logic        busy_o, done_o, fault_o;
    logic [1:0]  fault_code_o, fault_stage_o, cur_stage_o;
    logic [15:0] run_cnt_o;
    logic [31:0] cycle_cnt_o;
    logic [2:0]  dbg_state_o;

    bch_flow_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .cfg_encode_en_i  (cfg_encode_en_i),
        .cfg_noise_en_i   (cfg_noise_en_i),
        .cfg_errgen_en_i  (cfg_errgen_en_i),
        .cfg_num_errors_i (cfg_num_errors_i),
        .cfg_t_i          (cfg_t_i),
        .stg_start_o      (stg_start_o),
        .stg_done_i       (stg_done_i),
        .err_count_o      (err_count_o),
        .syn_count_o      (syn_count_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .fault_o          (fault_o),
        .fault_code_o     (fault_code_o),
        .fault_stage_o    (fault_stage_o),
        .cur_stage_o      (cur_stage_o),
        .run_cnt_o        (run_cnt_o),
        .cycle_cnt_o      (cycle_cnt_o),
        .dbg_state_o      (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stage engine models ----------------
    logic [3:0] eng_done, man_done, mute;
    int         eng_cnt [4];

    assign stg_done_i = eng_done | man_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_done <= '0;
            for (int i = 0; i < 4; i++) eng_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stg_start_o[i]) eng_cnt[i] <= ENG_DELAY - 1;
                else if (eng_cnt[i] > 0) eng_cnt[i] <= eng_cnt[i] - 1;
                eng_done[i] <= (eng_cnt[i] == 1) && !mute[i];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int         errors = 0;
    int         checks = 0;
    int         exp_runs = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (stg_start_o != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stg_start: got=%0d expected=none", stg_start_o);
            end else begin
                check("stg_start", 32'(stg_start_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cfg(input logic enc, input logic noise, input logic errg,
                             input logic [7:0] nerr, input logic [2:0] t);
        cfg_encode_en_i  = enc;
        cfg_noise_en_i   = noise;
        cfg_errgen_en_i  = errg;
        cfg_num_errors_i = nerr;
        cfg_t_i          = t;
    endtask

    task automatic push_seq(input int n, input logic [15:0] seq);
        for (int i = 0; i < n; i++) exp_q.push_back(seq[4*i +: 4]);
    endtask

    // Leaves the bench one cycle after acceptance (cycle 1).
    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_end(input int lat0, input int budget, output int lat);
        lat = lat0;
        while (!(done_o || fault_o) && (lat < budget)) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!(done_o || fault_o)) begin
            checks++;
            errors++;
            $display("FAIL wait_end: got=no done/fault expected=end within %0d cycles", budget);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        enc, noise, errg;
        logic [7:0]  nerr;
        logic [2:0]  t;
        int          nstg;
        logic [15:0] seq;
        logic [1:0]  code;
        logic [7:0]  exp_err;
        logic [3:0]  exp_syn;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat;
        int exp_lat;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 8'd3,  3'd2, 4, 16'h8421, 2'd0, 8'd3,  4'd4};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'd2,  3'd0, 1, 16'h0004, 2'd0, 8'd2,  4'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'd15, 3'd0, 0, 16'h0000, 2'd2, 8'd15, 4'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd0,  3'd5, 0, 16'h0000, 2'd2, 8'd0,  4'd10};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd7,  3'd3, 0, 16'h0000, 2'd0, 8'd7,  4'd6};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 8'd14, 3'd4, 3, 16'h0821, 2'd0, 8'd14, 4'd8};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'd0,  3'd0, 1, 16'h0002, 2'd0, 8'd0,  4'd0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'd1,  3'd0, 0, 16'h0000, 2'd2, 8'd1,  4'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 8'd14, 3'd1, 1, 16'h0004, 2'd0, 8'd14, 4'd2};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 8'd0,  3'd1, 2, 16'h0081, 2'd0, 8'd0,  4'd2};

        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        man_done = '0; mute = '0;
        drive_cfg(1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
        idle(3);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_fault", 32'(fault_o), 0);
        check("rst_run_cnt", 32'(run_cnt_o), 0);
        check("rst_cycle_cnt", cycle_cnt_o, 0);
        check("rst_state", 32'(dbg_state_o), 0);
        rst = 1'b0;
        idle(2);

        // Table-driven runs
        for (int v = 0; v < 10; v++) begin
            drive_cfg(vecs[v].enc, vecs[v].noise, vecs[v].errg, vecs[v].nerr, vecs[v].t);
            push_seq(vecs[v].nstg, vecs[v].seq);
            pulse_start();
            wait_end(1, 200, lat);
            exp_lat = (vecs[v].code != 2'd0) ? 1 : 1 + 6 * vecs[v].nstg;
            check($sformatf("v%0d_latency", v), lat, exp_lat);
            check($sformatf("v%0d_done", v), 32'(done_o), 32'(vecs[v].code == 2'd0));
            check($sformatf("v%0d_fault", v), 32'(fault_o), 32'(vecs[v].code != 2'd0));
            check($sformatf("v%0d_fault_code", v), 32'(fault_code_o), 32'(vecs[v].code));
            check($sformatf("v%0d_err_count", v), 32'(err_count_o), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_syn_count", v), 32'(syn_count_o), 32'(vecs[v].exp_syn));
            check($sformatf("v%0d_busy", v), 32'(busy_o), 0);
            if (vecs[v].code == 2'd0) exp_runs++;
            idle(1);
            check($sformatf("v%0d_cycle_cnt", v), cycle_cnt_o, 32'(exp_lat + 1));
            check($sformatf("v%0d_run_cnt", v), 32'(run_cnt_o), 32'(exp_runs));
            idle(2);
        end
        check("full_state_done_dbg", 32'(dbg_state_o), 3);

        // Timeout on NOISE: engine never answers
        drive_cfg(1'b1, 1'b1, 1'b0, 8'd0, 3'd2);
        mute = 4'b0010;
        push_seq(2, 16'h0021);
        pulse_start();
        wait_end(1, 2000, lat);
        check("tmo_latency", lat, 1032);
        check("tmo_fault", 32'(fault_o), 1);
        check("tmo_code", 32'(fault_code_o), 1);
        check("tmo_stage", 32'(fault_stage_o), 1);
        check("tmo_done", 32'(done_o), 0);

        // Done on the last timeout cycle wins: restart from FAULT
        push_seq(3, 16'h0821);
        pulse_start();
        check("restart_fault_cleared", 32'(fault_o), 0);
        idle(1030);
        man_done = 4'b0010;
        idle(1);
        man_done = 4'b0000;
        mute = 4'b0000;
        wait_end(1032, 1200, lat);
        check("lastcyc_latency", lat, 1038);
        check("lastcyc_done", 32'(done_o), 1);
        check("lastcyc_fault", 32'(fault_o), 0);
        exp_runs++;
        idle(2);

        // Abort during DEC WAIT, concurrent with DEC done
        drive_cfg(1'b1, 1'b1, 1'b1, 8'd3, 3'd2);
        push_seq(4, 16'h8421);
        pulse_start();
        idle(21);
        abort_i = 1'b1;
        man_done = 4'b1000;
        idle(1);
        abort_i = 1'b0;
        man_done = 4'b0000;
        check("abort_fault", 32'(fault_o), 1);
        check("abort_code", 32'(fault_code_o), 3);
        check("abort_stage", 32'(fault_stage_o), 3);
        check("abort_done", 32'(done_o), 0);
        check("abort_run_cnt", 32'(run_cnt_o), 32'(exp_runs));
        idle(6);
        check("abort_hold_fault", 32'(fault_o), 1);

        // Start while busy is ignored
        drive_cfg(1'b1, 1'b1, 1'b1, 8'd3, 3'd2);
        push_seq(4, 16'h8421);
        pulse_start();
        idle(2);
        drive_cfg(1'b0, 1'b0, 1'b1, 8'd9, 3'd1);
        pulse_start();
        wait_end(4, 200, lat);
        exp_runs++;
        check("busy_start_latency", lat, 25);
        check("busy_start_err_count", 32'(err_count_o), 3);
        check("busy_start_syn_count", 32'(syn_count_o), 4);
        check("busy_start_cur_stage", 32'(cur_stage_o), 3);
        // Abort in DONE is ignored
        abort_i = 1'b1;
        idle(1);
        abort_i = 1'b0;
        check("done_abort_ignored_done", 32'(done_o), 1);
        check("done_abort_ignored_fault", 32'(fault_o), 0);
        check("full_cycle_cnt", cycle_cnt_o, 26);
        check("full_run_cnt", 32'(run_cnt_o), 32'(exp_runs));

        // Same-cycle start and abort in DONE: start wins
        drive_cfg(1'b0, 1'b0, 1'b1, 8'd2, 3'd0);
        push_seq(1, 16'h0004);
        abort_i = 1'b1;
        pulse_start();
        abort_i = 1'b0;
        wait_end(1, 200, lat);
        exp_runs++;
        check("start_abort_latency", lat, 7);
        check("start_abort_done", 32'(done_o), 1);
        check("start_abort_fault", 32'(fault_o), 0);
        idle(2);

        // Reset mid-WAIT
        drive_cfg(1'b1, 1'b1, 1'b1, 8'd3, 3'd2);
        push_seq(4, 16'h8421);
        pulse_start();
        idle(3);
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_runs = 0;
        check("midrst_start", 32'(stg_start_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_done", 32'(done_o), 0);
        check("midrst_err_count", 32'(err_count_o), 0);
        check("midrst_syn_count", 32'(syn_count_o), 0);
        check("midrst_run_cnt", 32'(run_cnt_o), 0);
        check("midrst_cycle_cnt", cycle_cnt_o, 0);
        check("midrst_cur_stage", 32'(cur_stage_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Recovery run after reset
        drive_cfg(1'b0, 1'b0, 1'b1, 8'd5, 3'd0);
        push_seq(1, 16'h0004);
        pulse_start();
        wait_end(1, 200, lat);
        exp_runs++;
        check("post_rst_latency", lat, 7);
        check("post_rst_run_cnt", 32'(run_cnt_o), 32'(exp_runs));
        idle(3);

        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bch_flow_ctrl.md
Name: bch_flow_ctrl

Overview:
- Run sequencer for the BCH test datapath. It launches and supervises the stage engines in a fixed order: encoder, Gaussian-noise adder, random error injector, syndrome decoder.
- Configuration comes from the AXI-Lite register block and is latched at run start. Each stage gets a one-cycle start pulse, and the block waits for that stage's done pulse.
- Disabled stages are skipped. A per-stage watchdog is applied, and status plus run statistics are reported back to the registers.

Parameters:
- CODE_LEN, 14, codeword length in bits; upper bound for the requested error count.
- MAX_T, 4, maximum correcting capability accepted.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles per stage before a fault.
- CNT_W, 32, width of the run cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  run request pulse.
- abort_i  in  1  abort request.
- cfg_encode_en_i  in  1  enables the encode stage and the decode stage.
- cfg_noise_en_i  in  1  enables the noise stage.
- cfg_errgen_en_i  in  1  enables the error-injection stage.
- cfg_num_errors_i  in  8  number of bit errors to inject.
- cfg_t_i  in  3  correcting capability t.
- stg_start_o  out  4  one-hot start pulse: bit0 ENC, bit1 NOISE, bit2 ERRGEN, bit3 DEC.
- stg_done_i  in  4  per-stage done pulses.
- err_count_o  out  8  latched cfg_num_errors, fed to the error injector.
- syn_count_o  out  4  latched 2*t, fed to the decoder (number of syndromes).
- busy_o  out  1  run in progress.
- done_o  out  1  last run completed OK (level).
- fault_o  out  1  last run faulted (level).
- fault_code_o  out  2  0 none, 1 timeout, 2 bad config, 3 abort.
- fault_stage_o  out  2  stage index active at fault.
- cur_stage_o  out  2  current stage index.
- run_cnt_o  out  16  number of successful runs, wraps.
- cycle_cnt_o  out  CNT_W  cycles of the current or last run.

Behaviour:
- Reset: every output is 0. State is IDLE; latched config, stage index, watchdog timer and counters are all 0.
- States: IDLE, ISSUE, WAIT, DONE, FAULT.
- Start acceptance: start_i is accepted only in IDLE, DONE or FAULT, and is ignored while busy.
- On acceptance (cycle 0):
  - latch the config and clear done_o, fault_o, fault_code_o and cycle_cnt_o;
  - set err_count_o = cfg_num_errors and syn_count_o = 2*cfg_t.
- Config validation at acceptance, in priority order:
  - Bad config (cfg_num_errors > CODE_LEN with errgen enabled, or cfg_t == 0 or cfg_t > MAX_T with encode enabled): go to FAULT at cycle 1 with code 2, fault_stage 0.
  - No stage enabled: go to DONE at cycle 1.
  - Otherwise: go to ISSUE with the first enabled stage.
- Stage order: ENC(0) if encode_en, NOISE(1) if noise_en, ERRGEN(2) if errgen_en, DEC(3) if encode_en. Next stage = lowest enabled index greater than the current one.
- ISSUE: lasts exactly one cycle.
  - stg_start_o[stage] = 1 (registered, so it is high during the ISSUE cycle); busy_o = 1.
  - Clear the watchdog timer, then go to WAIT.
  - stg_done_i is ignored during ISSUE.
- WAIT: the timer increments every cycle.
  - stg_done_i[stage] = 1: go to ISSUE of the next stage in the following cycle, or to DONE if none remains.
  - The timer reaches TIMEOUT_CYCLES-1 with no done: go to FAULT, code 1, fault_stage = stage.
  - Done and timeout expiry in the same cycle: done wins.
  - Done bits of non-current stages are ignored.
- Abort: abort_i in ISSUE or WAIT goes to FAULT next cycle with code 3; abort beats a simultaneous done. abort_i in IDLE, DONE or FAULT is ignored.
- Same-cycle start and abort in DONE/FAULT: start is accepted and the abort is ignored.
- DONE: done_o = 1, busy_o = 0, run_cnt_o += 1 once on entry. Hold until the next accepted start.
- FAULT: fault_o = 1, busy_o = 0. Hold until the next accepted start.
- cycle_cnt_o: counts every cycle from acceptance until DONE/FAULT entry inclusive, then freezes. Saturates at all-ones.
- cur_stage_o tracks the stage index register and holds its last value in DONE/FAULT.
- Latency: start_i at cycle 0 gives the first stg_start_o at cycle 1. A done at cycle n gives the next stg_start_o, or done_o, at cycle n+1.
- Reset mid-run: immediate return to reset values; no start pulse is emitted.

Decomposition:
- bch_ctrl_pkg holds:
  - the state enum (3-bit);
  - stage index constants STG_ENC=0, STG_NOISE=1, STG_ERRGEN=2, STG_DEC=3;
  - fault code constants FLT_NONE/TIMEOUT/CFG/ABORT.
- Sub-module bch_stage_select (combinational): takes the enable mask and current index; outputs next index and a none-left flag. Instantiated for both first-stage and next-stage lookup.
- The watchdog timer and counters stay inline.

Test Plan:
- Full run: all enables, num_errors=3, t=2. Each engine model returns done 5 cycles after its start. Expect stg_start_o pulses 1, 2, 4, 8 at cycles 1, 7, 13, 19; done_o at 25; run_cnt_o=1; cycle_cnt_o=26; syn_count_o=4; err_count_o=3.
- Skip: only errgen enabled, num_errors=2. Expect a single stg_start_o=4; done_o after its done; ENC, NOISE and DEC never pulsed.
- Bad config: errgen enabled with num_errors=15, or encode enabled with t=5. Expect fault_o=1, fault_code_o=2 at cycle 1, and no stg_start_o pulse.
- Timeout: NOISE model never answers, TIMEOUT_CYCLES=1024. Expect fault_code_o=1, fault_stage_o=1 after 1024 WAIT cycles. A done on the last timeout cycle instead yields normal progression.
- Abort: abort_i during DEC WAIT, concurrent with stg_done_i[3]. Expect fault_code_o=3, fault_stage_o=3, done_o=0, and run_cnt_o unchanged.
- Restart and reset: start_i in FAULT clears fault_o and runs normally. rst asserted mid-WAIT returns all outputs to 0 immediately. start_i while busy is ignored.
